uart_rx: RTL and testbench

- 8N1-style UART receiver driven by the 16x oversampling tick from the team's baud-rate generator.
- Detects the start bit, samples each bit at mid-bit, and assembles the word LSB first.
- Presents the word on a valid/ready handshake and flags framing and overrun errors.
- Sits between the serial RX pin and the consuming logic, e.g. the command decoder or FIFO.

---
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampled start/stop UART receiver with valid/ready output
// Mid-bit sampling driven by an external oversample tick; framing and overrun flagged as pulses.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [TW-1:0] HALF_T   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_T   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 sync1_q, sync1_d;
  logic                 rxs_q, rxs_d;
  logic                 rxp_q, rxp_d;
  logic [1:0]           state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 busy_q, busy_d;
  logic [TW-1:0]        tgt;
  logic                 hit;

  always_comb begin
    sync1_d       = rx;
    rxs_d         = sync1_q;
    rxp_d         = rxs_q;
    state_d       = state_q;
    tcnt_d        = tcnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
    tgt           = (state_q == START) ? HALF_T : FULL_T;
    hit           = tick && (tcnt_q == tgt);

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    if (tick && state_q != IDLE) begin
      tcnt_d = hit ? '0 : tcnt_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        // Only a high-to-low transition starts a frame; a held-low line stays idle.
        if (rxp_q && !rxs_q) begin
          state_d = START;
          tcnt_d  = '0;
        end
      end
      START: begin
        if (hit) begin
          if (!rxs_q) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (hit) begin
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end
      end
      default: begin
        // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
        if (hit) begin
          state_d = IDLE;
          if (!rxs_q) begin
            frame_err_d = 1'b1;
          end else if (rx_valid_q && !rx_ready) begin
            overrun_err_d = 1'b1;
          end else begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end
        end
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= 1'b1;
      rxs_q         <= 1'b1;
      rxp_q         <= 1'b1;
      state_q       <= IDLE;
      tcnt_q        <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      rxs_q         <= rxs_d;
      rxp_q         <= rxp_d;
      state_q       <= state_d;
      tcnt_q        <= tcnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
      busy_q        <= busy_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
// Frames are driven at 64 clk per bit (tick every 4 clk); received words are collected by a monitor.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] got[$];
  int         ferr_cnt, oerr_cnt, rise_cnt, fall_cnt, first_rise_cyc;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .rx         (rx),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    int tdiv;
    tdiv = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tick = (tdiv == 3);
      tdiv = (tdiv + 1) % 4;
    end
  end

  // Inputs only change at negedges, so rx_ready seen here is the value the last edge used.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rx_valid && (!prev_valid || rx_ready)) got.push_back(rx_data);
      if (rx_valid && !prev_valid) begin
        rise_cnt++;
        if (first_rise_cyc < 0) first_rise_cyc = cyc;
      end
      if (!rx_valid && prev_valid) fall_cnt++;
      if (frame_err) ferr_cnt++;
      if (overrun_err) oerr_cnt++;
      if (prev_valid && !rx_ready && rx_valid) begin
        checks++;
        if (rx_data !== prev_data) begin
          errors++;
          $display("FAIL data_stable got=%0h exp=%0h", rx_data, prev_data);
        end
      end
      prev_valid = rx_valid;
      prev_data  = rx_data;
    end
  end

  function automatic logic [7:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 8'hxx;
  endfunction

  task automatic clear_mon();
    got.delete();
    ferr_cnt       = 0;
    oerr_cnt       = 0;
    rise_cnt       = 0;
    fall_cnt       = 0;
    first_rise_cyc = -1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle(input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%0h exp=0", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL reset_oerr got=%b exp=0", overrun_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic [7:0] d;
    int start_cyc, lat;
    d = 8'hA5;
    clear_mon();
    idle(1);
    start_cyc = cyc;
    send_bit(1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_mid got=%b exp=1", busy); end
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    idle(1);
    checks++; if (rise_cnt != 1) begin errors++; $display("FAIL single_rises got=%0d exp=1", rise_cnt); end
    checks++;
    if (got.size() != 1 || got_at(0) !== d) begin
      errors++; $display("FAIL single_data got=%0h n=%0d exp=%0h", got_at(0), got.size(), d);
    end
    checks++;
    if (ferr_cnt != 0 || oerr_cnt != 0) begin
      errors++; $display("FAIL single_errs got ferr=%0d oerr=%0d exp=0", ferr_cnt, oerr_cnt);
    end
    lat = first_rise_cyc - start_cyc;
    checks++;
    if (lat < 606 || lat > 613) begin
      errors++; $display("FAIL single_latency got=%0d exp=606..613", lat);
    end
  endtask

  task automatic test_false_start();
    clear_mon();
    rx = 1'b0;
    repeat (12) @(negedge clk);
    idle(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL false_busy got=%b exp=0", busy); end
    checks++;
    if (got.size() != 0 || ferr_cnt != 0 || oerr_cnt != 0) begin
      errors++; $display("FAIL false_quiet got words=%0d ferr=%0d oerr=%0d exp=0", got.size(), ferr_cnt, oerr_cnt);
    end
    send_frame(8'h3C, 1'b1);
    idle(1);
    checks++;
    if (got.size() != 1 || got_at(0) !== 8'h3C) begin
      errors++; $display("FAIL false_next got=%0h n=%0d exp=3c", got_at(0), got.size());
    end
  endtask

  task automatic test_frame_err();
    logic [7:0] d;
    clear_mon();
    send_frame(8'h55, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    checks++; if (ferr_cnt != 1) begin errors++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt); end
    checks++; if (rise_cnt != 0) begin errors++; $display("FAIL ferr_valid got=%0d exp=0", rise_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_retrigger got=%b exp=0", busy); end
    idle(1);
    d = 8'($urandom);
    send_frame(d, 1'b1);
    idle(1);
    checks++;
    if (got.size() != 1 || got_at(0) !== d || ferr_cnt != 1) begin
      errors++; $display("FAIL ferr_recover got=%0h n=%0d ferr=%0d exp=%0h", got_at(0), got.size(), ferr_cnt, d);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    rx_ready = 1'b0;
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    idle(1);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b exp=1", rx_valid); end
    checks++; if (rx_data !== 8'h01) begin errors++; $display("FAIL b2b_data got=%0h exp=01", rx_data); end
    checks++; if (oerr_cnt != 2) begin errors++; $display("FAIL b2b_overruns got=%0d exp=2", oerr_cnt); end
    checks++;
    if (ferr_cnt != 0 || got.size() != 1) begin
      errors++; $display("FAIL b2b_misc got ferr=%0d words=%0d exp 0/1", ferr_cnt, got.size());
    end
    rx_ready = 1'b1;
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_accept got=%b exp=0", rx_valid); end
    idle(1);
  endtask

  task automatic test_simultaneous();
    clear_mon();
    rx_ready = 1'b0;
    send_frame(8'h01, 1'b1);
    idle(1);
    fork
      send_frame(8'h02, 1'b1);
      begin
        int n;
        n = 0;
        // Edge seen after 3 clk; the load happens on the 152nd tick after that (8 + 8*16 + 16).
        repeat (3) @(posedge clk);
        while (n < 152) begin
          @(negedge clk);
          if (tick) n++;
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    idle(1);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL simul_valid got=%b exp=1", rx_valid); end
    checks++; if (rx_data !== 8'h02) begin errors++; $display("FAIL simul_data got=%0h exp=02", rx_data); end
    checks++; if (oerr_cnt != 0) begin errors++; $display("FAIL simul_overrun got=%0d exp=0", oerr_cnt); end
    checks++; if (fall_cnt != 0) begin errors++; $display("FAIL simul_gap got=%0d exp=0", fall_cnt); end
    rx_ready = 1'b1;
    idle(1);
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    rx_ready = 1'b0;
    send_frame(8'h42, 1'b1);
    idle(1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
      errors++; $display("FAIL rst_mid_word got valid=%b data=%0h exp 0/00", rx_valid, rx_data);
    end
    checks++;
    if (busy !== 1'b0 || frame_err !== 1'b0 || overrun_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_flags got busy=%b ferr=%b oerr=%b exp 0", busy, frame_err, overrun_err);
    end
    repeat (4) @(negedge clk);
    reset = 1'b0;
    rx_ready = 1'b1;
    idle(6);
    send_frame(8'h81, 1'b1);
    idle(1);
    checks++;
    if (got.size() != 2 || got_at(1) !== 8'h81 || ferr_cnt != 0 || oerr_cnt != 0) begin
      errors++; $display("FAIL rst_mid_next got=%0h n=%0d ferr=%0d oerr=%0d exp=81", got_at(1), got.size(), ferr_cnt, oerr_cnt);
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic       stop;
    int         gap, nfe;
    clear_mon();
    nfe = 0;
    for (int k = 0; k < 10; k++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      send_frame(d, stop);
      if (stop) exp_q.push_back(d);
      else nfe++;
      idle(gap);
    end
    idle(1);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got=%0d exp=%0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_at(i) !== exp_q[i]) begin
        errors++; $display("FAIL rand_word[%0d] got=%0h exp=%0h", i, got_at(i), exp_q[i]);
      end
    end
    checks++; if (ferr_cnt != nfe) begin errors++; $display("FAIL rand_ferr got=%0d exp=%0d", ferr_cnt, nfe); end
    checks++; if (oerr_cnt != 0) begin errors++; $display("FAIL rand_oerr got=%0d exp=0", oerr_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_false_start();
    test_frame_err();
    test_back_to_back();
    test_simultaneous();
    test_reset_midframe();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
